// File: rtl/hash_table_requester.sv
// hash_table_requester
//   Initiator-side companion to the hash table stream wrapper. Takes one host
//   command at a time, packs it as {op, key, data}, and sends it over a
//   valid/ready request channel. It then waits for the 32-bit response and
//   returns a decoded result to the host.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   cmd_*               host command channel (op, key, write data)
//   req_*               request word to the hash table (valid/ready)
//   resp_*              response word from the hash table (valid/ready)
//   result_*            decoded result to the host (valid/ready)
//   ops_count_o         saturating count of completed results
//   err_count_o         saturating count of results carrying any error
//
// Parameters
//   DATA_WIDTH must be <= 28 so that read data does not overlap the flags in
//   resp_data_i[31:28]. TIMEOUT_CYCLES must be >= 1.
module hash_table_requester #(
  parameter int KEY_WIDTH      = 5,
  parameter int DATA_WIDTH     = 25,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic [1:0]                        cmd_op_i,
  input  logic [KEY_WIDTH-1:0]              cmd_key_i,
  input  logic [DATA_WIDTH-1:0]             cmd_data_i,
  output logic [2+KEY_WIDTH+DATA_WIDTH-1:0] req_data_o,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  input  logic [31:0]                       resp_data_i,
  input  logic                              resp_valid_i,
  output logic                              resp_ready_o,
  output logic                              result_valid_o,
  input  logic                              result_ready_i,
  output logic [DATA_WIDTH-1:0]             result_data_o,
  output logic [3:0]                        result_flags_o,
  output logic                              result_timeout_o,
  output logic                              result_badop_o,
  output logic [COUNT_WIDTH-1:0]            ops_count_o,
  output logic [COUNT_WIDTH-1:0]            err_count_o
);

  // The timer must be able to hold TIMEOUT_CYCLES itself, because it takes
  // one more increment on the cycle that leaves WAIT.
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_RESERVED = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } state_t;

  state_t                   state_q,        state_d;
  logic [1:0]               op_q,           op_d;
  logic [KEY_WIDTH-1:0]     key_q,          key_d;
  logic [DATA_WIDTH-1:0]    data_q,         data_d;
  logic [TIMER_WIDTH-1:0]   timer_q,        timer_d;
  logic [DATA_WIDTH-1:0]    res_data_q,     res_data_d;
  logic [3:0]               res_flags_q,    res_flags_d;
  logic                     res_timeout_q,  res_timeout_d;
  logic                     res_badop_q,    res_badop_d;
  logic [COUNT_WIDTH-1:0]   ops_count_q,    ops_count_d;
  logic [COUNT_WIDTH-1:0]   err_count_q,    err_count_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    data_d        = data_q;
    timer_d       = timer_q;
    res_data_d    = res_data_q;
    res_flags_d   = res_flags_q;
    res_timeout_d = res_timeout_q;
    res_badop_d   = res_badop_q;
    ops_count_d   = ops_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d          = cmd_op_i;
          key_d         = cmd_key_i;
          // Only writes carry a payload. The request word shows zero data otherwise.
          data_d        = (cmd_op_i == OP_WRITE) ? cmd_data_i : '0;
          // Start every transaction with a clean result record.
          res_data_d    = '0;
          res_flags_d   = '0;
          res_timeout_d = 1'b0;
          res_badop_d   = (cmd_op_i == OP_RESERVED);
          // A reserved op is rejected locally and never reaches the table.
          state_d       = (cmd_op_i == OP_RESERVED) ? ST_REPORT : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (req_ready_i) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        // If a response arrives on the expiry cycle, the response takes priority.
        if (resp_valid_i) begin
          res_flags_d = resp_data_i[31:28];
          res_data_d  = ((op_q == OP_READ) && (resp_data_i[31:28] == 4'b0000))
                        ? resp_data_i[DATA_WIDTH-1:0] : '0;
          state_d     = ST_REPORT;
        end else if (timer_q == TIMER_LAST) begin
          // This is the TIMEOUT_CYCLES-th cycle spent in WAIT.
          res_timeout_d = 1'b1;
          state_d       = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (result_ready_i) begin
          if (~&ops_count_q) begin
            ops_count_d = ops_count_q + COUNT_WIDTH'(1);
          end
          if (((|res_flags_q) || res_timeout_q || res_badop_q) && (~&err_count_q)) begin
            err_count_d = err_count_q + COUNT_WIDTH'(1);
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      key_q         <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_timeout_q <= 1'b0;
      res_badop_q   <= 1'b0;
      ops_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      key_q         <= key_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_timeout_q <= res_timeout_d;
      res_badop_q   <= res_badop_d;
      ops_count_q   <= ops_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // Handshake outputs are decoded only from the state register. This keeps
  // every input-to-output path broken by a flop.
  assign cmd_ready_o      = (state_q == ST_IDLE);
  assign req_valid_o      = (state_q == ST_ISSUE);
  assign resp_ready_o     = (state_q == ST_WAIT);
  assign result_valid_o   = (state_q == ST_REPORT);
  assign req_data_o       = {op_q, key_q, data_q};
  assign result_data_o    = res_data_q;
  assign result_flags_o   = res_flags_q;
  assign result_timeout_o = res_timeout_q;
  assign result_badop_o   = res_badop_q;
  assign ops_count_o      = ops_count_q;
  assign err_count_o      = err_count_q;

endmodule

// File: tb/tb_hash_table_requester.sv
module tb_hash_table_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [4:0]  cmd_key_i = '0;
  logic [24:0] cmd_data_i = '0;
  logic [31:0] req_data_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        resp_valid_i = 1'b0;
  logic        resp_ready_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [24:0] result_data_o;
  logic [3:0]  result_flags_o;
  logic        result_timeout_o;
  logic        result_badop_o;
  logic [3:0]  ops_count_o;
  logic [3:0]  err_count_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hash_table_requester #(
    .KEY_WIDTH(5),
    .DATA_WIDTH(25),
    .TIMEOUT_CYCLES(8),
    .COUNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i),
    .cmd_key_i(cmd_key_i),
    .cmd_data_i(cmd_data_i),
    .req_data_o(req_data_o),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .resp_data_i(resp_data_i),
    .resp_valid_i(resp_valid_i),
    .resp_ready_o(resp_ready_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_data_o(result_data_o),
    .result_flags_o(result_flags_o),
    .result_timeout_o(result_timeout_o),
    .result_badop_o(result_badop_o),
    .ops_count_o(ops_count_o),
    .err_count_o(err_count_o)
  );

  // Stimulus helpers: drive only, never compare.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] key, input logic [24:0] data);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_key_i   = key;
    cmd_data_i  = data;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic accept_req();
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
  endtask

  task automatic send_resp(input logic [31:0] d);
    resp_valid_i = 1'b1;
    resp_data_i  = d;
    step();
    resp_valid_i = 1'b0;
    resp_data_i  = '0;
  endtask

  task automatic take_result();
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0h exp=1", cmd_ready_o); end
    total++; if ({req_valid_o, resp_ready_o, result_valid_o} !== 3'b000) begin bad++; $display("FAIL rst_valids got=%b exp=000", {req_valid_o, resp_ready_o, result_valid_o}); end
    total++; if (req_data_o !== 32'h0) begin bad++; $display("FAIL rst_req_data got=%h exp=0", req_data_o); end
    total++; if ({ops_count_o, err_count_o} !== 8'h00) begin bad++; $display("FAIL rst_counters got=%h exp=00", {ops_count_o, err_count_o}); end
    total++; if ({result_data_o, result_flags_o, result_timeout_o, result_badop_o} !== 31'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", {result_data_o, result_flags_o}); end
    reset = 1'b1;
    step();
    $display("txn reset: released");
  endtask

  task automatic test_write_read();
    // Write key 5, data 0x1234567 -> {01, 00101, 0x1234567} = 0x4B234567.
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL wr_cmd_ready got=%0h exp=1", cmd_ready_o); end
    send_cmd(2'b01, 5'd5, 25'h1234567);
    total++; if (req_valid_o !== 1'b1) begin bad++; $display("FAIL wr_req_valid got=%0h exp=1", req_valid_o); end
    total++; if (req_data_o !== 32'h4B23_4567) begin bad++; $display("FAIL wr_req_data got=%h exp=4b234567", req_data_o); end
    total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL wr_cmd_ready_busy got=%0h exp=0", cmd_ready_o); end
    accept_req();
    total++; if ({req_valid_o, resp_ready_o} !== 2'b01) begin bad++; $display("FAIL wr_wait got=%b exp=01", {req_valid_o, resp_ready_o}); end
    send_resp(32'h0000_0000);
    total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL wr_result_valid got=%0h exp=1", result_valid_o); end
    total++; if ({result_flags_o, result_data_o} !== 29'h0) begin bad++; $display("FAIL wr_result got=%h/%h exp=0/0", result_flags_o, result_data_o); end
    take_result();
    total++; if ({result_valid_o, cmd_ready_o} !== 2'b01) begin bad++; $display("FAIL wr_back_idle got=%b exp=01", {result_valid_o, cmd_ready_o}); end
    total++; if (ops_count_o !== 4'd1) begin bad++; $display("FAIL wr_ops got=%0d exp=1", ops_count_o); end
    $display("txn write key=5 data=1234567 done");

    // Read key 5 with stray data on the bus -> {00, 00101, 0} = 0x0A000000.
    send_cmd(2'b00, 5'd5, 25'h1555555);
    total++; if (req_data_o !== 32'h0A00_0000) begin bad++; $display("FAIL rd_req_data got=%h exp=0a000000", req_data_o); end
    accept_req();
    send_resp(32'h0123_4567);
    total++; if (result_data_o !== 25'h1234567) begin bad++; $display("FAIL rd_result_data got=%h exp=1234567", result_data_o); end
    total++; if (result_flags_o !== 4'b0000) begin bad++; $display("FAIL rd_result_flags got=%b exp=0000", result_flags_o); end
    take_result();
    total++; if (ops_count_o !== 4'd2) begin bad++; $display("FAIL rd_ops got=%0d exp=2", ops_count_o); end
    total++; if (err_count_o !== 4'd0) begin bad++; $display("FAIL rd_err got=%0d exp=0", err_count_o); end
    $display("txn read key=5 data=%h", 25'h1234567);
  endtask

  task automatic test_read_miss();
    send_cmd(2'b00, 5'd3, 25'h0000155);
    total++; if (req_data_o !== 32'h0600_0000) begin bad++; $display("FAIL miss_req_data got=%h exp=06000000", req_data_o); end
    accept_req();
    send_resp(32'h41FF_FFFF);
    total++; if (result_flags_o !== 4'b0100) begin bad++; $display("FAIL miss_flags got=%b exp=0100", result_flags_o); end
    total++; if (result_data_o !== 25'h0) begin bad++; $display("FAIL miss_data got=%h exp=0", result_data_o); end
    take_result();
    total++; if ({ops_count_o, err_count_o} !== {4'd3, 4'd1}) begin bad++; $display("FAIL miss_counters got=%0d/%0d exp=3/1", ops_count_o, err_count_o); end
    $display("txn read miss key=3");
  endtask

  task automatic test_backpressure();
    // Write key 7, data 0x0ABCDEF -> {01, 00111, 0x0ABCDEF} = 0x4EABCDEF.
    send_cmd(2'b01, 5'd7, 25'h0ABCDEF);
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b00;
    cmd_key_i   = 5'd1;
    cmd_data_i  = 25'h1;
    for (int i = 0; i < 10; i++) begin
      total++; if ({req_valid_o, cmd_ready_o, result_valid_o} !== 3'b100) begin bad++; $display("FAIL bp_req_hold[%0d] got=%b exp=100", i, {req_valid_o, cmd_ready_o, result_valid_o}); end
      total++; if (req_data_o !== 32'h4EAB_CDEF) begin bad++; $display("FAIL bp_req_data[%0d] got=%h exp=4eabcdef", i, req_data_o); end
      step();
    end
    cmd_valid_i = 1'b0;
    accept_req();
    total++; if ({resp_ready_o, result_timeout_o} !== 2'b10) begin bad++; $display("FAIL bp_no_timeout got=%b exp=10", {resp_ready_o, result_timeout_o}); end
    send_resp(32'h8000_0055);
    for (int i = 0; i < 5; i++) begin
      total++; if ({result_valid_o, result_flags_o, result_data_o} !== {1'b1, 4'b1000, 25'h0}) begin bad++; $display("FAIL bp_result_hold[%0d] got=%b/%b/%h exp=1/1000/0", i, result_valid_o, result_flags_o, result_data_o); end
      total++; if ({ops_count_o, err_count_o} !== {4'd3, 4'd1}) begin bad++; $display("FAIL bp_counters_hold[%0d] got=%0d/%0d exp=3/1", i, ops_count_o, err_count_o); end
      step();
    end
    take_result();
    total++; if ({ops_count_o, err_count_o} !== {4'd4, 4'd2}) begin bad++; $display("FAIL bp_counters got=%0d/%0d exp=4/2", ops_count_o, err_count_o); end
    $display("txn backpressured write key=7 flags=1000");
  endtask

  task automatic test_timeout();
    send_cmd(2'b00, 5'd9, 25'h0);
    accept_req();
    // WAIT entered at this edge; seven more edges must still be in WAIT.
    for (int i = 1; i < 8; i++) begin
      step();
      total++; if ({result_valid_o, resp_ready_o} !== 2'b01) begin bad++; $display("FAIL to_early[%0d] got=%b exp=01", i, {result_valid_o, resp_ready_o}); end
    end
    step();
    total++; if ({result_valid_o, result_timeout_o} !== 2'b11) begin bad++; $display("FAIL to_expire got=%b exp=11", {result_valid_o, result_timeout_o}); end
    total++; if ({result_flags_o, result_data_o} !== 29'h0) begin bad++; $display("FAIL to_fields got=%b/%h exp=0/0", result_flags_o, result_data_o); end
    take_result();
    total++; if ({ops_count_o, err_count_o} !== {4'd5, 4'd3}) begin bad++; $display("FAIL to_counters got=%0d/%0d exp=5/3", ops_count_o, err_count_o); end
    $display("txn read key=9 timeout");

    // Response on the expiry cycle wins over the timeout.
    send_cmd(2'b00, 5'd9, 25'h0);
    accept_req();
    repeat (7) step();
    total++; if (resp_ready_o !== 1'b1) begin bad++; $display("FAIL race_wait got=%0h exp=1", resp_ready_o); end
    send_resp(32'h0000_0ABC);
    total++; if ({result_valid_o, result_timeout_o} !== 2'b10) begin bad++; $display("FAIL race_timeout got=%b exp=10", {result_valid_o, result_timeout_o}); end
    total++; if (result_data_o !== 25'h0000ABC) begin bad++; $display("FAIL race_data got=%h exp=abc", result_data_o); end
    take_result();
    total++; if ({ops_count_o, err_count_o} !== {4'd6, 4'd3}) begin bad++; $display("FAIL race_counters got=%0d/%0d exp=6/3", ops_count_o, err_count_o); end
    $display("txn read key=9 response on expiry cycle");
  endtask

  task automatic test_badop();
    send_cmd(2'b11, 5'd2, 25'h1FFFFFF);
    for (int i = 0; i < 3; i++) begin
      total++; if ({req_valid_o, result_valid_o, result_badop_o} !== 3'b011) begin bad++; $display("FAIL badop_state[%0d] got=%b exp=011", i, {req_valid_o, result_valid_o, result_badop_o}); end
      step();
    end
    total++; if ({result_flags_o, result_data_o} !== 29'h0) begin bad++; $display("FAIL badop_fields got=%b/%h exp=0/0", result_flags_o, result_data_o); end
    take_result();
    total++; if ({ops_count_o, err_count_o} !== {4'd7, 4'd4}) begin bad++; $display("FAIL badop_counters got=%0d/%0d exp=7/4", ops_count_o, err_count_o); end
    $display("txn reserved op rejected");
  endtask

  task automatic test_async_reset();
    send_cmd(2'b00, 5'd1, 25'h0);
    accept_req();
    total++; if (resp_ready_o !== 1'b1) begin bad++; $display("FAIL ar_in_wait got=%0h exp=1", resp_ready_o); end
    #2;
    reset = 1'b0;
    #1;
    // Still between clock edges here.
    total++; if ({cmd_ready_o, resp_ready_o, req_valid_o, result_valid_o} !== 4'b1000) begin bad++; $display("FAIL ar_handshake got=%b exp=1000", {cmd_ready_o, resp_ready_o, req_valid_o, result_valid_o}); end
    total++; if ({ops_count_o, err_count_o} !== 8'h00) begin bad++; $display("FAIL ar_counters got=%h exp=00", {ops_count_o, err_count_o}); end
    total++; if (req_data_o !== 32'h0) begin bad++; $display("FAIL ar_req_data got=%h exp=0", req_data_o); end
    step();
    reset = 1'b1;
    step();
    resp_valid_i = 1'b1;
    resp_data_i  = 32'h0000_0077;
    #1;
    total++; if (resp_ready_o !== 1'b0) begin bad++; $display("FAIL ar_late_resp_ready got=%0h exp=0", resp_ready_o); end
    step();
    resp_valid_i = 1'b0;
    total++; if ({result_valid_o, cmd_ready_o, ops_count_o} !== {1'b0, 1'b1, 4'd0}) begin bad++; $display("FAIL ar_late_ignored got=%b exp=010000", {result_valid_o, cmd_ready_o, ops_count_o}); end
    $display("txn async reset in WAIT");
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    for (int i = 1; i <= 17; i++) begin
      send_cmd(2'b11, 5'd0, 25'h0);
      take_result();
      exp_cnt = (i < 15) ? 4'(i) : 4'd15;
      total++; if ({ops_count_o, err_count_o} !== {exp_cnt, exp_cnt}) begin bad++; $display("FAIL sat_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, ops_count_o, err_count_o, exp_cnt, exp_cnt); end
      $display("txn badop #%0d ops=%0d err=%0d", i, ops_count_o, err_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_miss();
    test_backpressure();
    test_timeout();
    test_badop();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
